multdiv_controller: RTL and testbench

- Sequences the shared iterative multiply/divide unit for the 5-stage pipeline.
- Detects a valid `mul` or `div` in the execute (X) stage and stalls F/D/X.
- Issues a one-cycle start pulse to the multdiv unit, waits for its ready flag (with a watchdog), then presents one writeback result to the X/M latch.
- On exception, redirects the write to rstatus (r30) with a status code, consistent with `setx`/`bex` usage.

---
 rtl/multdiv_controller_pkg.sv | 15 +
 rtl/md_decode.sv | 26 ++
 rtl/multdiv_controller.sv | 144 ++++++++++++++
 tb/tb_multdiv_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_controller_pkg.sv
// Shared decode constants and state encoding for the multiply/divide sequencer.
package multdiv_controller_pkg;

    localparam logic [4:0] OPCODE_ALU = 5'b00000;
    localparam logic [4:0] ALUOP_MULT = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    localparam logic [4:0] STATUS_REG = 5'd30;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StBusy  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/md_decode.sv
// Combinational mul/div detector for the X-stage instruction; shared with the hazard unit.
module md_decode
    import multdiv_controller_pkg::*;
(
    input  logic [31:0] dx_instruction,
    input  logic        dx_valid,
    output logic        is_mult,
    output logic        is_div,
    output logic [4:0]  rd
);

    logic       alu_op;
    logic [4:0] aluop;
    logic       unused_bits;

    assign unused_bits = ^{dx_instruction[21:7], dx_instruction[1:0]};

    always_comb begin
        aluop   = dx_instruction[6:2];
        alu_op  = dx_valid && (dx_instruction[31:27] == OPCODE_ALU);
        is_mult = alu_op && (aluop == ALUOP_MULT);
        is_div  = alu_op && (aluop == ALUOP_DIV);
        rd      = dx_instruction[26:22];
    end

endmodule

// File: rtl/multdiv_controller.sv
// Sequences the shared iterative multiply/divide unit: stall, start pulse, watchdog, writeback.
module multdiv_controller
    import multdiv_controller_pkg::*;
#(
    parameter int unsigned MAX_CYCLES  = 40,
    parameter int unsigned MULT_STATUS = 4,
    parameter int unsigned DIV_STATUS  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_instruction,
    input  logic        dx_valid,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_exception
);

    localparam int unsigned    CntW     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_CYCLES - 1);
    localparam logic [31:0]    MultCode = 32'(MULT_STATUS);
    localparam logic [31:0]    DivCode  = 32'(DIV_STATUS);

    logic            is_mult;
    logic            is_div;
    logic [4:0]      dec_rd;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op_div_q, op_div_d;
    logic [4:0]      rd_q, rd_d;
    logic            exc_q, exc_d;
    logic            ctrl_mult_q, ctrl_mult_d;
    logic            ctrl_div_q, ctrl_div_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            finish;
    logic            finish_exc;

    md_decode u_md_decode (
        .dx_instruction (dx_instruction),
        .dx_valid       (dx_valid),
        .is_mult        (is_mult),
        .is_div         (is_div),
        .rd             (dec_rd)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_div_d    = op_div_q;
        rd_d        = rd_q;
        exc_d       = exc_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        stall       = 1'b0;
        finish      = 1'b0;
        finish_exc  = 1'b0;

        case (state_q)
            StIdle: begin
                stall = is_mult | is_div;
                if (is_mult | is_div) begin
                    op_div_d    = is_div;
                    rd_d        = dec_rd;
                    ctrl_mult_d = is_mult;
                    ctrl_div_d  = is_div;
                    state_d     = StStart;
                end
            end
            StStart: begin
                stall   = 1'b1;
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                stall = 1'b1;
                // A ready result takes priority over a coincident watchdog expiry.
                if (md_ready) begin
                    finish     = 1'b1;
                    finish_exc = md_exception;
                end else if (cnt_q == CntLast) begin
                    finish     = 1'b1;
                    finish_exc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            state_d   = StDone;
            exc_d     = finish_exc;
            wb_rd_d   = finish_exc ? STATUS_REG : rd_q;
            wb_data_d = finish_exc ? (op_div_q ? DivCode : MultCode) : md_result;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_div_q    <= 1'b0;
            rd_q        <= '0;
            exc_q       <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_div_q    <= op_div_d;
            rd_q        <= rd_d;
            exc_q       <= exc_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign ctrl_mult    = ctrl_mult_q;
    assign ctrl_div     = ctrl_div_q;
    assign wb_valid     = (state_q == StDone);
    assign wb_exception = (state_q == StDone) && exc_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: fixed vector table, directed sequences and a random pipeline run.
module tb_multdiv_controller;

    localparam int unsigned MAX = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dx_instruction;
    logic        dx_valid;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_exception;

    always #5 clock = ~clock;

    multdiv_controller #(
        .MAX_CYCLES  (MAX),
        .MULT_STATUS (4),
        .DIV_STATUS  (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dx_instruction (dx_instruction),
        .dx_valid       (dx_valid),
        .md_ready       (md_ready),
        .md_exception   (md_exception),
        .md_result      (md_result),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_exception   (wb_exception)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one in-flight transaction tracked by its age in cycles since detection.
    bit          m_act, m_done, m_div, m_exc;
    int          m_age;
    logic [4:0]  m_rd, l_rd;
    logic [31:0] l_data;

    function automatic void ref_decode(input logic [31:0] ins, input logic v,
                                       output bit md, output bit dv);
        int unsigned op, alu;
        op  = 32'(ins >> 27);
        alu = 32'((ins >> 2) & 32'd31);
        md  = v && (op == 0) && (alu == 6 || alu == 7);
        dv  = (alu == 7);
    endfunction

    function automatic logic [41:0] mk(input logic cm, input logic cd, input logic st,
                                       input logic wv, input logic wx, input logic [4:0] rd,
                                       input logic [31:0] d);
        return {cm, cd, st, wv, wx, rd, d};
    endfunction

    function automatic logic [41:0] model_expect();
        bit md, dv;
        ref_decode(dx_instruction, dx_valid, md, dv);
        return mk(m_act && m_age == 1 && !m_div, m_act && m_age == 1 && m_div,
                  m_act ? !m_done : md, m_done, m_done && m_exc, l_rd, l_data);
    endfunction

    task automatic model_finish(input bit ex, input logic [31:0] res);
        m_done = 1;
        m_exc  = ex;
        l_rd   = ex ? 5'd30 : m_rd;
        l_data = ex ? (m_div ? 32'd5 : 32'd4) : res;
    endtask

    task automatic model_step();
        bit md, dv;
        ref_decode(dx_instruction, dx_valid, md, dv);
        if (reset) begin
            m_act = 0; m_done = 0; m_age = 0; l_rd = '0; l_data = '0;
        end else if (!m_act) begin
            if (md) begin
                m_act = 1; m_age = 1; m_div = dv; m_rd = 5'((dx_instruction >> 22) & 32'd31);
            end
        end else if (m_done) begin
            m_act = 0; m_done = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            if (md_ready) model_finish(md_exception, md_result);
            else if (m_age - 1 == int'(MAX)) model_finish(1'b1, 32'd0);
            m_age++;
        end
    endtask

    // Observation records used by the directed sequences.
    int          cyc = 0, n_cm = 0, n_cd = 0, n_wbv = 0, cm_cyc = 0, wb_cyc = 0;
    bit          s_exp_stall;
    logic        s_stall, s_wbx;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [4:0]  wbq[$];

    task automatic cycle(input logic rst, input logic [31:0] ins, input logic v, input logic rdy,
                         input logic ex, input logic [31:0] res, input bit chk_model,
                         input bit use_tab, input logic [41:0] tab, input string name);
        logic [41:0] obs, e;
        @(negedge clock);
        reset = rst; dx_instruction = ins; dx_valid = v;
        md_ready = rdy; md_exception = ex; md_result = res;
        #1;
        obs = {ctrl_mult, ctrl_div, stall, wb_valid, wb_exception, wb_rd, wb_data};
        e   = model_expect();
        if (chk_model) check({name, " model"}, 64'(obs), 64'(e));
        if (use_tab) check(name, 64'(obs), 64'(tab));
        s_exp_stall = e[39];
        s_stall     = stall;
        cyc++;
        if (ctrl_mult === 1'b1) begin n_cm++; cm_cyc = cyc; end
        if (ctrl_div === 1'b1) n_cd++;
        if (wb_valid === 1'b1) begin
            n_wbv++; wb_cyc = cyc; wbq.push_back(wb_rd);
            s_rd = wb_rd; s_data = wb_data; s_wbx = wb_exception;
        end
        @(posedge clock);
        model_step();
    endtask

    // X-stage emulation: the head of xq stays in X until the model says stall is low.
    typedef struct { logic [31:0] ins; logic v; } xs_t;
    xs_t xq[$];

    task automatic pipe_run(input int n, input int mode, input logic ex_fixed, input string name);
        xs_t  cur;
        logic rdy, ex, rst;
        for (int i = 0; i < n; i++) begin
            cur = (xq.size() > 0) ? xq[0] : '{32'd0, 1'b0};
            rst = 1'b0;
            case (mode)
                0:       begin rdy = 1'b1; ex = ex_fixed; end
                1:       begin rdy = 1'b0; ex = 1'b0; end
                default: begin
                    rdy = ($urandom_range(0, 3) == 0);
                    ex  = ($urandom_range(0, 3) == 0);
                    rst = ($urandom_range(0, 149) == 0);
                end
            endcase
            cycle(rst, cur.ins, cur.v, rdy, ex, $urandom, 1, 0, '0, name);
            if (!s_exp_stall && xq.size() > 0) void'(xq.pop_front());
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] aluop);
        return {op, rd, 15'd0, aluop, 2'd0};
    endfunction

    function automatic void clear_obs();
        n_cm = 0; n_cd = 0; n_wbv = 0; cm_cyc = 0; wb_cyc = 0;
        wbq.delete();
    endfunction

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        v, rdy, ex;
        logic [31:0] res;
        logic [41:0] exp;
    } vec_t;

    vec_t tab[12];

    initial begin
        logic [31:0] mul7, add2, addi, r;
        mul7 = enc(5'd0, 5'd7, 5'b00110);
        add2 = enc(5'd0, 5'd2, 5'b00000);
        addi = enc(5'b00101, 5'd2, 5'b00110);

        tab[0]  = '{1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 0, 0, 5'd0, 32'd0)};
        tab[1]  = '{1'b0, mul7,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 1, 0, 0, 5'd0, 32'd0)};
        tab[2]  = '{1'b0, mul7,  1'b1, 1'b0, 1'b0, 32'd0,  mk(1, 0, 1, 0, 0, 5'd0, 32'd0)};
        tab[3]  = '{1'b0, mul7,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 1, 0, 0, 5'd0, 32'd0)};
        tab[4]  = '{1'b0, mul7,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 1, 0, 0, 5'd0, 32'd0)};
        tab[5]  = '{1'b0, mul7,  1'b1, 1'b1, 1'b0, 32'd42, mk(0, 0, 1, 0, 0, 5'd0, 32'd0)};
        tab[6]  = '{1'b0, mul7,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 1, 0, 5'd7, 32'd42)};
        tab[7]  = '{1'b0, add2,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 0, 0, 5'd7, 32'd42)};
        tab[8]  = '{1'b0, addi,  1'b1, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 0, 0, 5'd7, 32'd42)};
        tab[9]  = '{1'b0, mul7,  1'b0, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 0, 0, 5'd7, 32'd42)};
        tab[10] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd99, mk(0, 0, 0, 0, 0, 5'd7, 32'd42)};
        tab[11] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0,  mk(0, 0, 0, 0, 0, 5'd7, 32'd42)};

        // First edge only establishes a known state.
        cycle(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0, '0, "init");

        for (int i = 0; i < 12; i++) begin
            cycle(tab[i].rst, tab[i].ins, tab[i].v, tab[i].rdy, tab[i].ex, tab[i].res,
                  1, 1, tab[i].exp, $sformatf("table[%0d]", i));
        end

        // div with exception reported on the first BUSY cycle.
        clear_obs();
        xq.push_back('{enc(5'd0, 5'd9, 5'b00111), 1'b1});
        pipe_run(6, 0, 1'b1, "div_exc");
        check("div_exc ctrl_mult count", 64'(n_cm), 64'd0);
        check("div_exc ctrl_div count", 64'(n_cd), 64'd1);
        check("div_exc wb_valid count", 64'(n_wbv), 64'd1);
        check("div_exc wb {exc,rd,data}", {26'd0, s_wbx, s_rd, s_data}, {26'd0, 1'b1, 5'd30, 32'd5});

        // mul whose result never arrives: watchdog forces the status write.
        clear_obs();
        xq.push_back('{enc(5'd0, 5'd5, 5'b00110), 1'b1});
        pipe_run(MAX + 6, 1, 1'b0, "timeout");
        check("timeout pulse-to-writeback cycles", 64'(wb_cyc - cm_cyc), 64'(MAX + 1));
        check("timeout wb {exc,rd,data}", {26'd0, s_wbx, s_rd, s_data}, {26'd0, 1'b1, 5'd30, 32'd4});
        check("timeout final stall", 64'(s_stall), 64'd0);

        // Back-to-back mul then div.
        clear_obs();
        xq.push_back('{enc(5'd0, 5'd3, 5'b00110), 1'b1});
        xq.push_back('{enc(5'd0, 5'd4, 5'b00111), 1'b1});
        xq.push_back('{add2, 1'b1});
        pipe_run(12, 0, 1'b0, "b2b");
        check("b2b ctrl_mult count", 64'(n_cm), 64'd1);
        check("b2b ctrl_div count", 64'(n_cd), 64'd1);
        check("b2b wb_valid count", 64'(wbq.size()), 64'd2);
        if (wbq.size() == 2) begin
            check("b2b first wb_rd", 64'(wbq[0]), 64'd3);
            check("b2b second wb_rd", 64'(wbq[1]), 64'd4);
        end

        // Reset during BUSY, then a late md_ready.
        clear_obs();
        xq.delete();
        xq.push_back('{enc(5'd0, 5'd6, 5'b00110), 1'b1});
        pipe_run(4, 1, 1'b0, "abort");
        xq.delete();
        cycle(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1, 0, '0, "abort reset");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd77, 1, 0, '0, "abort stray ready");
        end
        check("abort wb_valid count", 64'(n_wbv), 64'd0);
        check("abort pulse count", 64'(n_cm + n_cd), 64'd1);
        check("abort final stall", 64'(s_stall), 64'd0);

        // Random pipeline traffic against the model.
        for (int blk = 0; blk < 200; blk++) begin
            if (xq.size() == 0) begin
                for (int k = 0; k < 4; k++) begin
                    case ($urandom_range(0, 3))
                        0: r = enc(5'd0, 5'($urandom), 5'b00110);
                        1: r = enc(5'd0, 5'($urandom), 5'b00111);
                        2: r = enc(5'd0, 5'($urandom), 5'b00000);
                        default: r = enc(5'b00101, 5'($urandom), 5'b00110);
                    endcase
                    xq.push_back('{r | ($urandom & 32'h003F_FF83), $urandom_range(0, 3) != 0});
                end
            end
            pipe_run(4, 2, 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
